// File: rtl/mem_write_queue.sv
// mem_write_queue: in-order store buffer between the execute stage and memory.
// Accepts writes from execute, merges a write into the newest queued entry
// when the address matches and that entry is not the head, and drains to
// memory over a valid/ready handshake.
//
// Parameters
//   mem_addr_width  width of a memory address
//   width           width of a data word
//   depth           number of entries (power of two, >= 2)
//
// Ports
//   clk_i        clock, rising edge
//   reset_ni     asynchronous active-low reset
//   wr_valid_i   execute presents a write
//   wr_addr_i    write address
//   wr_data_i    write data
//   wr_ready_o   queue can take a write this cycle
//   mem_valid_o  head entry valid towards memory
//   mem_addr_o   head entry address
//   mem_data_o   head entry data
//   mem_ready_i  memory accepts the head entry
//   count_o      occupied entries
//   empty_o      queue empty (write fence for execute)
//   overflow_o   sticky: write offered while full
module mem_write_queue #(
    parameter int mem_addr_width = 16,
    parameter int width          = 32,
    parameter int depth          = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      wr_valid_i,
    input  logic [mem_addr_width-1:0] wr_addr_i,
    input  logic [width-1:0]          wr_data_i,
    output logic                      wr_ready_o,
    output logic                      mem_valid_o,
    output logic [mem_addr_width-1:0] mem_addr_o,
    output logic [width-1:0]          mem_data_o,
    input  logic                      mem_ready_i,
    output logic [$clog2(depth):0]    count_o,
    output logic                      empty_o,
    output logic                      overflow_o
);

    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(depth);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);
    localparam logic [CW-1:0] TWO_CNT   = CW'(2);
    localparam logic [CW-1:0] THREE_CNT = CW'(3);

    // Storage is intentionally not reset; only entries between head and
    // tail are ever presented to memory.
    logic [mem_addr_width-1:0] addr_q [depth];
    logic [width-1:0]          data_q [depth];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          coalesce;
    logic          alloc;
    logic          merge_room;
    logic [PW-1:0] newest;
    logic [PW-1:0] wr_idx;

    // Status derived only from registered state, so wr_ready_o has no
    // combinational path from mem_ready_i.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    assign wr_ready_o  = !full;
    assign mem_valid_o = !empty;
    assign empty_o     = empty;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign mem_addr_o  = addr_q[head_q];
    assign mem_data_o  = data_q[head_q];

    assign push   = wr_valid_i && !full;
    assign pop    = !empty && mem_ready_i;
    assign newest = tail_q - PW'(1);

    // Merging is only legal if the newest entry is still behind the head
    // once this edge's pop has retired: at least two entries must remain.
    assign merge_room = pop ? (count_q >= THREE_CNT)
                            : (count_q >= TWO_CNT);

    assign coalesce = push && merge_room
                      && (addr_q[newest] == wr_addr_i);
    assign alloc    = push && !coalesce;
    assign wr_idx   = coalesce ? newest : tail_q;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (pop) begin
            head_d = head_q + PW'(1);
        end

        if (alloc) begin
            tail_d = tail_q + PW'(1);
        end

        if (alloc && !pop) begin
            count_d = count_q + ONE_CNT;
        end else if (!alloc && pop) begin
            count_d = count_q - ONE_CNT;
        end

        if (wr_valid_i && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_idx] <= wr_addr_i;
            data_q[wr_idx] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_mem_write_queue.sv
// tb_mem_write_queue: directed self-checking bench for mem_write_queue.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_write_queue;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        wr_valid_i;
    logic [15:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic        wr_ready_o;
    logic        mem_valid_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_ready_i;
    logic [2:0]  count_o;
    logic        empty_o;
    logic        overflow_o;

    int checks   = 0;
    int failures = 0;

    mem_write_queue #(
        .mem_addr_width(16),
        .width(32),
        .depth(4)
    ) dut (
        .clk_i(clk_i),
        .reset_ni(reset_ni),
        .wr_valid_i(wr_valid_i),
        .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i),
        .wr_ready_o(wr_ready_o),
        .mem_valid_o(mem_valid_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o),
        .mem_ready_i(mem_ready_i),
        .count_o(count_o),
        .empty_o(empty_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then return at the next falling edge.
    task automatic cyc(input logic wv, input logic [15:0] a,
                       input logic [31:0] d, input logic mr);
        wr_valid_i  = wv;
        wr_addr_i   = a;
        wr_data_i   = d;
        mem_ready_i = mr;
        @(negedge clk_i);
    endtask

    task automatic head(input string tag, input logic [15:0] a,
                        input logic [31:0] d);
        chk({tag, "_valid"}, 64'(mem_valid_o), 64'd1);
        chk({tag, "_addr"}, 64'(mem_addr_o), 64'(a));
        chk({tag, "_data"}, 64'(mem_data_o), 64'(d));
    endtask

    initial begin
        reset_ni    = 1'b0;
        wr_valid_i  = 1'b0;
        wr_addr_i   = '0;
        wr_data_i   = '0;
        mem_ready_i = 1'b0;

        // Reset state, before any clock edge
        #3;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_mvalid", 64'(mem_valid_o), 64'd0);
        chk("rst_wready", 64'(wr_ready_o), 64'd1);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);

        // Single write; no pass-through before the edge
        wr_valid_i  = 1'b1;
        wr_addr_i   = 16'h0010;
        wr_data_i   = 32'hDEADBEEF;
        mem_ready_i = 1'b1;
        #1;
        chk("single_nopass", 64'(mem_valid_o), 64'd0);
        @(negedge clk_i);
        head("single", 16'h0010, 32'hDEADBEEF);
        chk("single_cnt", 64'(count_o), 64'd1);
        cyc(1'b0, 16'h0, 32'h0, 1'b1);
        chk("single_empty", 64'(empty_o), 64'd1);

        // Fill, backpressure, overflow, ordered drain
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 16'(i), 32'h100 + 32'(i), 1'b0);
        end
        chk("fill_cnt", 64'(count_o), 64'd4);
        chk("fill_wready", 64'(wr_ready_o), 64'd0);
        chk("fill_ovf0", 64'(overflow_o), 64'd0);
        cyc(1'b1, 16'h5, 32'h105, 1'b0);
        chk("ovf_cnt", 64'(count_o), 64'd4);
        chk("ovf_set", 64'(overflow_o), 64'd1);
        head("ovf_head", 16'h1, 32'h101);
        for (int i = 1; i <= 4; i++) begin
            head("drain", 16'(i), 32'h100 + 32'(i));
            cyc(1'b0, 16'h0, 32'h0, 1'b1);
        end
        chk("drain_empty", 64'(empty_o), 64'd1);
        chk("ovf_sticky", 64'(overflow_o), 64'd1);

        // Coalesce into newest non-head entry
        cyc(1'b1, 16'h20, 32'd1, 1'b0);
        cyc(1'b1, 16'h30, 32'd2, 1'b0);
        cyc(1'b1, 16'h30, 32'd3, 1'b0);
        chk("coal_cnt", 64'(count_o), 64'd2);
        head("coal_h0", 16'h20, 32'd1);
        cyc(1'b0, 16'h0, 32'h0, 1'b1);
        head("coal_h1", 16'h30, 32'd3);
        cyc(1'b0, 16'h0, 32'h0, 1'b1);
        chk("coal_empty", 64'(empty_o), 64'd1);

        // No coalesce into the head
        cyc(1'b1, 16'h40, 32'd7, 1'b0);
        cyc(1'b1, 16'h40, 32'd8, 1'b0);
        chk("nohead_cnt", 64'(count_o), 64'd2);
        head("nohead_h0", 16'h40, 32'd7);
        cyc(1'b0, 16'h0, 32'h0, 1'b1);
        head("nohead_h1", 16'h40, 32'd8);
        cyc(1'b0, 16'h0, 32'h0, 1'b1);
        chk("nohead_empty", 64'(empty_o), 64'd1);

        // Coalesce with pop (3 -> 2); same address at count 2 with pop
        // must allocate because the newest would become the head.
        cyc(1'b1, 16'h70, 32'd1, 1'b0);
        cyc(1'b1, 16'h71, 32'd2, 1'b0);
        cyc(1'b1, 16'h72, 32'd3, 1'b0);
        cyc(1'b1, 16'h72, 32'd4, 1'b1);
        chk("cpop_cnt", 64'(count_o), 64'd2);
        head("cpop_h0", 16'h71, 32'd2);
        cyc(1'b1, 16'h72, 32'd5, 1'b1);
        chk("cpop2_cnt", 64'(count_o), 64'd2);
        head("cpop_h1", 16'h72, 32'd4);
        cyc(1'b0, 16'h0, 32'h0, 1'b1);
        head("cpop_h2", 16'h72, 32'd5);
        cyc(1'b0, 16'h0, 32'h0, 1'b1);
        chk("cpop_empty", 64'(empty_o), 64'd1);

        // Streaming at count 1, pointers wrap several times
        cyc(1'b1, 16'h60, 32'd0, 1'b1);
        for (int i = 1; i < 10; i++) begin
            head("stream", 16'h60 + 16'(i - 1), 32'(i - 1));
            chk("stream_cnt", 64'(count_o), 64'd1);
            cyc(1'b1, 16'h60 + 16'(i), 32'(i), 1'b1);
        end
        head("stream_last", 16'h69, 32'd9);
        cyc(1'b0, 16'h0, 32'h0, 1'b1);
        chk("stream_empty", 64'(empty_o), 64'd1);

        // Asynchronous reset mid-operation
        cyc(1'b1, 16'h80, 32'd1, 1'b0);
        cyc(1'b1, 16'h81, 32'd2, 1'b0);
        cyc(1'b1, 16'h82, 32'd3, 1'b0);
        wr_valid_i = 1'b0;
        chk("arst_pre_cnt", 64'(count_o), 64'd3);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("arst_mvalid", 64'(mem_valid_o), 64'd0);
        chk("arst_cnt", 64'(count_o), 64'd0);
        chk("arst_empty", 64'(empty_o), 64'd1);
        chk("arst_wready", 64'(wr_ready_o), 64'd1);
        chk("arst_ovf", 64'(overflow_o), 64'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        cyc(1'b1, 16'h50, 32'd9, 1'b0);
        head("arst_push", 16'h50, 32'd9);
        chk("arst_push_cnt", 64'(count_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_write_queue.md
MEM_WRITE_QUEUE -- requirements
Module: mem_write_queue

Interface
REQ-001 Parameter mem_addr_width, default 16, width of a memory address.
REQ-002 Parameter width, default 32, width of a data word; equal to the register width.
REQ-003 Parameter depth, default 4, number of entries; power of two, minimum 2.
REQ-004 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_ni  input  1  asynchronous, active-low reset.
REQ-006 wr_valid_i  input  1  execute stage presents a memory write.
REQ-007 wr_addr_i  input  mem_addr_width  write address, already offset-adjusted upstream.
REQ-008 wr_data_i  input  width  write data.
REQ-009 wr_ready_o  output  1  queue accepts a write this cycle.
REQ-010 mem_valid_o  output  1  head entry presented to memory.
REQ-011 mem_addr_o  output  mem_addr_width  head entry address.
REQ-012 mem_data_o  output  width  head entry data.
REQ-013 mem_ready_i  input  1  memory accepts the head entry.
REQ-014 count_o  output  $clog2(depth)+1  occupied entries.
REQ-015 empty_o  output  1  count_o == 0; used by the execute stage as a write fence.
REQ-016 overflow_o  output  1  sticky: a write was offered while the queue was full.

Function
REQ-017 Push: wr_valid_i && wr_ready_o at a rising edge; pop: mem_valid_o && mem_ready_i at a rising edge.
REQ-018 wr_ready_o = (count_o != depth), combinational from registered state only; no dependence on mem_ready_i (no pass-through when full).
REQ-019 mem_valid_o = !empty_o; mem_addr_o/mem_data_o are driven from the head storage entry, X-free whenever mem_valid_o=1.
REQ-020 Latency: a push at edge N makes the entry visible at the head no earlier than after edge N (cycle N+1 at the earliest).
REQ-021 While mem_valid_o=1 and mem_ready_i=0, mem_addr_o/mem_data_o remain stable.
REQ-022 Coalescing: on a push whose wr_addr_i equals the newest entry's address, with count_o >= 2 (after any pop this edge, the newest entry is still not the head), overwrite the newest entry's data; count is not incremented.
REQ-023 No coalescing into the head entry: with count_o == 1, or when the newest entry is the head, an equal address allocates a new entry.
REQ-024 Entries drain strictly in push order; head and tail pointers are log2(depth) bits and wrap modulo depth.
REQ-025 Simultaneous non-coalescing push and pop: count unchanged; a coalescing push with pop: count decrements by 1.
REQ-026 count_o never exceeds depth and never underflows; a pop while empty cannot occur (mem_valid_o=0).
REQ-027 wr_valid_i while full: write dropped, state unchanged, overflow_o set on that edge and held until reset.

Reset
REQ-028 With reset_ni low, immediately and independent of clk_i: count_o=0, empty_o=1, mem_valid_o=0, wr_ready_o=1, overflow_o=0, head and tail pointers at 0.
REQ-029 Storage data is not reset; mem_addr_o/mem_data_o are don't-care while mem_valid_o=0.
REQ-030 Reset asserted mid-operation discards all queued entries; the first push after deassertion lands in entry 0.

Verification
REQ-031 Single write: push addr 0x0010 data 0xDEADBEEF with mem_ready_i=1 -> next cycle mem_valid_o=1 with that addr/data; following cycle empty_o=1.
REQ-032 Fill/backpressure: mem_ready_i=0, push addrs 0x1,0x2,0x3,0x4 -> count_o=4, wr_ready_o=0; fifth push at 0x5 -> dropped, overflow_o=1; release mem_ready_i -> 0x1..0x4 drain in order over 4 cycles.
REQ-033 Coalesce: mem_ready_i=0, push (0x20,1),(0x30,2),(0x30,3) -> count_o=2; drain yields (0x20,1) then (0x30,3).
REQ-034 No head coalesce: mem_ready_i=0, push (0x40,7) then (0x40,8) -> count_o=2; drain yields 7 then 8.
REQ-035 Concurrent push/pop at count 1 with mem_ready_i=1 every cycle, 10 pushes to distinct addresses -> count_o stays 1, all 10 writes emerge in order, pointers wrap without loss.
REQ-036 Async reset: with count_o=3, pull reset_ni low between clock edges -> mem_valid_o=0 and count_o=0 before the next edge; after release, push (0x50,9) appears at head.
